cpri_blk_writer: RTL and testbench
==================================

Name: cpri_blk_writer

Overview:
- Upstream feeder of the asynchronous loop block buffer in the CPRI TX packager.
- Accepts a sop/eop-framed sample stream and packs each packet into one buffer block of 2**ADDR_WIDTH words.
- Drives the buffer write port: addr, data, wen, wlast and info.
- Throttles on the buffer's free_size block credit.

Parameters:
- DATA_WIDTH, 64: stream word and buffer write data width.
- ADDR_WIDTH, 8: in-block word address width; block holds 2**ADDR_WIDTH words.
- FREE_WIDTH, 2: width of the free_size credit input (loop width − ADDR_WIDTH + 1).
- INFO_WIDTH, 256: buffer info width; low 16 bits carry the word count.
- CNT_WIDTH, 16: status counter width.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- s_data, input, DATA_WIDTH: stream word.
- s_vld, input, 1: stream word valid.
- s_sop, input, 1: first word of packet.
- s_eop, input, 1: last word of packet.
- s_info, input, INFO_WIDTH-16: packet descriptor, sampled with the sop word.
- s_rdy, output, 1: stream ready; a word transfers when s_vld && s_rdy.
- free_size, input, FREE_WIDTH: free block count from the buffer.
- wr_addr, output, ADDR_WIDTH: in-block word address.
- wr_data, output, DATA_WIDTH: write data.
- wr_wen, output, 1: write enable.
- wr_wlast, output, 1: block-close strobe, coincident with the final write.
- wr_info, output, INFO_WIDTH: block descriptor, valid while wr_wlast=1.
- err_cnt, output, CNT_WIDTH: framing-error count, saturating.
- trunc_cnt, output, CNT_WIDTH: truncated-packet count, saturating.
- blk_cnt, output, CNT_WIDTH: blocks closed, wrapping.

Behaviour:
- Reset: all outputs 0; state IDLE; internal word count 0; captured descriptor 0. Reset asserted mid-packet abandons the block with no wlast.
- Latency: every wr_* output is registered, 1 cycle after the accepted input word.
- Write address: wr_addr equals the word index within the packet, starting at 0.
- Info format: wr_info[15:0] = number of data words written (1..2**ADDR_WIDTH); wr_info[INFO_WIDTH-1:16] = s_info captured at sop.
- State IDLE:
  - s_rdy = (free_size != 0).
  - Accepted word with s_sop=1: write it at addr 0. If s_eop=1 too, it is a single-word block: assert wlast and go to HOLD. Otherwise go to WRITE.
  - Accepted word with s_sop=0: drop it; err_cnt++.
- State WRITE:
  - s_rdy=1; each accepted word is written at the next address.
  - s_sop=1 inside WRITE: the word is written as data; err_cnt++.
  - s_eop=1: wlast on this word; go to HOLD.
  - Word index reaches 2**ADDR_WIDTH−1 without eop: wlast on this word; trunc_cnt++; go to DISCARD.
- State DISCARD:
  - s_rdy=1; words are dropped with no writes.
  - Accepted word with s_eop=1: go to HOLD.
- State HOLD:
  - s_rdy=0 for exactly 2 cycles, then IDLE.
  - Purpose: covers the registered-output cycle plus the buffer's free_size update cycle, so a stale credit is never used.
- blk_cnt increments on every wr_wlast.
- Credit boundaries:
  - free_size=0 in IDLE keeps s_rdy low indefinitely.
  - A credit return (free_size increment) during WRITE has no effect on the current block.
- s_vld=0 gaps in any state produce no writes and no state change.
- wr_wen=1 on every wr_wlast cycle.

Optional Feature:
- Macro: CPRI_BLK_PAD_EN.
- Defined:
  - After eop on a block of fewer than 2**ADDR_WIDTH words, enter state PAD instead of wlast on the eop word.
  - PAD: s_rdy=0; zero words written at consecutive addresses up to 2**ADDR_WIDTH−1; wlast on the final pad word; then HOLD.
  - wr_info[15:0] still reports the real data word count.
  - A full-length packet needs no padding.
- Undefined: no PAD state; wlast sits on the eop word.

Test Plan (ADDR_WIDTH=3, FREE_WIDTH=3, free_size held at 4 unless stated):
- 5-word packet, sop info=0xAB: wr_addr 0..4, wlast at addr 4, wr_info[15:0]=5, wr_info[23:16]=0xAB, blk_cnt=1; s_rdy low for 2 cycles after eop.
- 11-word packet: 8 writes, wlast at addr 7, wr_info[15:0]=8, trunc_cnt=1, 3 words absorbed with no writes, then HOLD.
- free_size=0, sop presented: s_rdy stays 0 and no writes; free_size set to 1: sop accepted the next cycle, write at addr 0.
- Two non-sop words in IDLE, then a sop mid-packet in WRITE: err_cnt=3; the mid-packet sop word is written as data.
- Single-word packet (sop=eop=1): one write at addr 0 with wlast, wr_info[15:0]=1.
- CPRI_BLK_PAD_EN, 3-word packet: data at addr 0..2, zeros at 3..7, wlast at addr 7, wr_info[15:0]=3.

Source files
------------

// File: rtl/cpri_blk_writer_if.sv
// Stream-in / buffer-write-out bundle for cpri_blk_writer.
// master: the block writer (consumes s_*, free_size; drives s_rdy, wr_*).
// slave: the far side (stream source plus block buffer write port).
// Ports: s_data, s_vld, s_sop, s_eop, s_info, s_rdy, free_size,
//        wr_addr, wr_data, wr_wen, wr_wlast, wr_info.
interface cpri_blk_writer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int FREE_WIDTH = 2,
    parameter int INFO_WIDTH = 256
) ();
    logic [DATA_WIDTH-1:0]    s_data;
    logic                     s_vld;
    logic                     s_sop;
    logic                     s_eop;
    logic [INFO_WIDTH-17:0]   s_info;
    logic                     s_rdy;
    logic [FREE_WIDTH-1:0]    free_size;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     wr_wen;
    logic                     wr_wlast;
    logic [INFO_WIDTH-1:0]    wr_info;

    modport master (
        input  s_data, s_vld, s_sop, s_eop, s_info, free_size,
        output s_rdy, wr_addr, wr_data, wr_wen, wr_wlast, wr_info
    );

    modport slave (
        output s_data, s_vld, s_sop, s_eop, s_info, free_size,
        input  s_rdy, wr_addr, wr_data, wr_wen, wr_wlast, wr_info
    );
endinterface

// File: rtl/cpri_blk_writer.sv
// Packs sop/eop-framed packets into fixed 2**ADDR_WIDTH-word buffer blocks.
// Ports: clk, rst (sync, active high), bus (cpri_blk_writer_if.master),
//        err_cnt / trunc_cnt (saturating), blk_cnt (wrapping).
// Optional macro CPRI_BLK_PAD_EN: zero-pad short blocks to full length.
module cpri_blk_writer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int FREE_WIDTH = 2,
    parameter int INFO_WIDTH = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cpri_blk_writer_if.master    bus,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] trunc_cnt,
    output logic [CNT_WIDTH-1:0] blk_cnt
);
    localparam logic [ADDR_WIDTH-1:0] LAST    = '1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   ONE     = 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        DISCARD,
`ifdef CPRI_BLK_PAD_EN
        PAD,
`endif
        HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [INFO_WIDTH-17:0]  info_q, info_d;
    logic                    hold_q, hold_d;
`ifdef CPRI_BLK_PAD_EN
    logic [ADDR_WIDTH:0]     len_q, len_d;
`endif

    logic                    rdy, acc;
    logic [FREE_WIDTH-1:0]   credit;
    logic [ADDR_WIDTH:0]     cnt_cur;
    logic                    wen_d, last_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic [INFO_WIDTH-1:0]   winfo_d;
    logic                    err_inc, trunc_inc;

    assign credit  = bus.free_size;
    // Words written so far including the one at idx_q.
    assign cnt_cur = {1'b0, idx_q} + ONE;

    // Credit is only consulted in IDLE; a block in flight already owns one.
    always_comb begin
        rdy = 1'b0;
        unique case (state_q)
            IDLE:           rdy = (credit != '0);
            WRITE, DISCARD: rdy = 1'b1;
            default:        rdy = 1'b0;
        endcase
        if (rst) rdy = 1'b0;
    end

    assign acc       = bus.s_vld && rdy;
    assign bus.s_rdy = rdy;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        info_d    = info_q;
        hold_d    = hold_q;
`ifdef CPRI_BLK_PAD_EN
        len_d     = len_q;
`endif
        wen_d     = 1'b0;
        last_d    = 1'b0;
        addr_d    = '0;
        data_d    = '0;
        winfo_d   = '0;
        err_inc   = 1'b0;
        trunc_inc = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (acc && bus.s_sop) begin
                    wen_d  = 1'b1;
                    data_d = bus.s_data;
                    info_d = bus.s_info;
                    idx_d  = IDX_ONE;
                    if (bus.s_eop) begin
`ifdef CPRI_BLK_PAD_EN
                        len_d   = ONE;
                        state_d = PAD;
`else
                        last_d  = 1'b1;
                        winfo_d = {bus.s_info, 16'(ONE)};
                        hold_d  = 1'b0;
                        state_d = HOLD;
`endif
                    end else begin
                        state_d = WRITE;
                    end
                end else if (acc) begin
                    err_inc = 1'b1;
                end
            end

            WRITE: begin
                if (acc) begin
                    wen_d   = 1'b1;
                    addr_d  = idx_q;
                    data_d  = bus.s_data;
                    idx_d   = idx_q + IDX_ONE;
                    err_inc = bus.s_sop;
                    // Full block closes on eop or on running out of room.
                    if (bus.s_eop || idx_q == LAST) begin
                        last_d    = 1'b1;
                        winfo_d   = {info_q, 16'(cnt_cur)};
                        trunc_inc = !bus.s_eop;
                        hold_d    = 1'b0;
                        state_d   = bus.s_eop ? HOLD : DISCARD;
                    end
`ifdef CPRI_BLK_PAD_EN
                    if (bus.s_eop && idx_q != LAST) begin
                        last_d  = 1'b0;
                        winfo_d = '0;
                        len_d   = cnt_cur;
                        state_d = PAD;
                    end
`endif
                end
            end

            DISCARD: begin
                if (acc && bus.s_eop) begin
                    hold_d  = 1'b0;
                    state_d = HOLD;
                end
            end

`ifdef CPRI_BLK_PAD_EN
            PAD: begin
                wen_d  = 1'b1;
                addr_d = idx_q;
                idx_d  = idx_q + IDX_ONE;
                if (idx_q == LAST) begin
                    last_d  = 1'b1;
                    winfo_d = {info_q, 16'(len_q)};
                    hold_d  = 1'b0;
                    state_d = HOLD;
                end
            end
`endif

            // Two dead cycles: registered wlast, then buffer credit update.
            HOLD: begin
                hold_d = 1'b1;
                if (hold_q) begin
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            info_q       <= '0;
            hold_q       <= 1'b0;
`ifdef CPRI_BLK_PAD_EN
            len_q        <= '0;
`endif
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.wr_wen   <= 1'b0;
            bus.wr_wlast <= 1'b0;
            bus.wr_info  <= '0;
            err_cnt      <= '0;
            trunc_cnt    <= '0;
            blk_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            info_q       <= info_d;
            hold_q       <= hold_d;
`ifdef CPRI_BLK_PAD_EN
            len_q        <= len_d;
`endif
            bus.wr_addr  <= addr_d;
            bus.wr_data  <= data_d;
            bus.wr_wen   <= wen_d;
            bus.wr_wlast <= last_d;
            bus.wr_info  <= winfo_d;
            if (err_inc && err_cnt != '1)
                err_cnt <= err_cnt + CNT_ONE;
            if (trunc_inc && trunc_cnt != '1)
                trunc_cnt <= trunc_cnt + CNT_ONE;
            if (last_d)
                blk_cnt <= blk_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_cpri_blk_writer.sv
// Directed bench for cpri_blk_writer with 8-word blocks.
// Expectations follow CPRI_BLK_PAD_EN when it is defined.
module tb_cpri_blk_writer;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int FW = 3;
    localparam int IW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CW-1:0] err_cnt, trunc_cnt, blk_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    logic          ql[$];
    logic [IW-1:0] qi[$];

    cpri_blk_writer_if #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .FREE_WIDTH(FW), .INFO_WIDTH(IW)
    ) bus ();

    cpri_blk_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FREE_WIDTH(FW),
        .INFO_WIDTH(IW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_cnt(err_cnt),
        .trunc_cnt(trunc_cnt),
        .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_wen) begin
            qa.push_back(bus.wr_addr);
            qd.push_back(bus.wr_data);
            ql.push_back(bus.wr_wlast);
            qi.push_back(bus.wr_info);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not reach summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic sop,
                        input logic eop, input logic [IW-17:0] info);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.s_data = d;
        bus.s_sop  = sop;
        bus.s_eop  = eop;
        bus.s_info = info;
        bus.s_vld  = 1'b1;
        #1;
        while (!bus.s_rdy && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!bus.s_rdy) check("rdy_timeout", 64'(bus.s_rdy), 64'd1);
        @(posedge clk);
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        bus.s_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        qa.delete();
        qd.delete();
        ql.delete();
        qi.delete();
    endtask

    task automatic check_block(input string t, input int n,
                               input logic [DW-1:0] base,
                               input logic [IW-1:0] info);
        int len;
        len = n;
`ifdef CPRI_BLK_PAD_EN
        len = 1 << AW;
`endif
        check({t, "_nwr"}, 64'(qa.size()), 64'(len));
        for (int i = 0; i < len && i < qa.size(); i++) begin
            check({t, "_addr"}, 64'(qa[i]), 64'(i));
            check({t, "_data"}, 64'(qd[i]),
                  (i < n) ? 64'(base + DW'(i)) : 64'd0);
            check({t, "_last"}, 64'(ql[i]), 64'(i == len - 1));
        end
        if (qa.size() == len)
            check({t, "_info"}, 64'(qi[len-1]), 64'(info));
        clear_q();
    endtask

    initial begin
        bus.s_data    = '0;
        bus.s_vld     = 1'b0;
        bus.s_sop     = 1'b0;
        bus.s_eop     = 1'b0;
        bus.s_info    = '0;
        bus.free_size = 3'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_rdy", 64'(bus.s_rdy), 0);
        check("rst_wen", 64'(bus.wr_wen), 0);
        check("rst_wlast", 64'(bus.wr_wlast), 0);
        check("rst_info", 64'(bus.wr_info), 0);
        check("rst_cnts", 64'({err_cnt, trunc_cnt, blk_cnt}), 0);
        rst = 1'b0;
        clear_q();

        // 5-word packet
        for (int i = 0; i < 5; i++)
            send(16'h100 + 16'(i), i == 0, i == 4, 16'hAB);
`ifndef CPRI_BLK_PAD_EN
        @(negedge clk);
        bus.s_vld = 1'b0;
        #1;
        check("t1_wlast_lat", 64'(bus.wr_wlast), 1);
        check("t1_blk", 64'(blk_cnt), 1);
        check("t1_hold0", 64'(bus.s_rdy), 0);
        @(negedge clk);
        #1;
        check("t1_hold1", 64'(bus.s_rdy), 0);
        @(negedge clk);
        #1;
        check("t1_idle", 64'(bus.s_rdy), 1);
`endif
        settle(12);
        check_block("t1", 5, 16'h100, 32'h00AB_0005);
        check("t1_blk_end", 64'(blk_cnt), 1);

        // 11-word packet truncated at 8
        for (int i = 0; i < 11; i++)
            send(16'h200 + 16'(i), i == 0, i == 10, 16'h22);
        @(negedge clk);
        bus.s_vld = 1'b0;
        #1;
        check("t2_hold0", 64'(bus.s_rdy), 0);
        @(negedge clk);
        #1;
        check("t2_hold1", 64'(bus.s_rdy), 0);
        @(negedge clk);
        #1;
        check("t2_idle", 64'(bus.s_rdy), 1);
        settle(4);
        check_block("t2", 8, 16'h200, 32'h0022_0008);
        check("t2_trunc", 64'(trunc_cnt), 1);
        check("t2_blk", 64'(blk_cnt), 2);

        // no credit
        @(negedge clk);
        bus.free_size = 3'd0;
        bus.s_data    = 16'h300;
        bus.s_sop     = 1'b1;
        bus.s_eop     = 1'b0;
        bus.s_info    = 16'h11;
        bus.s_vld     = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("t3_rdy_low", 64'(bus.s_rdy), 0);
        end
        check("t3_no_wr", 64'(qa.size()), 0);
        @(negedge clk);
        bus.free_size = 3'd1;
        #1;
        check("t3_rdy_up", 64'(bus.s_rdy), 1);
        @(posedge clk);
        #1;
        check("t3_wen", 64'(bus.wr_wen), 1);
        check("t3_addr0", 64'(bus.wr_addr), 0);
        send(16'h301, 1'b0, 1'b1, 16'h0);
        settle(12);
        bus.free_size = 3'd4;
        check_block("t3", 2, 16'h300, 32'h0011_0002);

        // framing errors
        send(16'hDEAD, 1'b0, 1'b0, 16'h0);
        send(16'hBEEF, 1'b0, 1'b1, 16'h0);
        settle(2);
        check("t4_err2", 64'(err_cnt), 2);
        check("t4_no_wr", 64'(qa.size()), 0);
        for (int i = 0; i < 4; i++)
            send(16'h400 + 16'(i), i == 0 || i == 2, i == 3, 16'h44);
        settle(12);
        check("t4_err3", 64'(err_cnt), 3);
        check_block("t4", 4, 16'h400, 32'h0044_0004);

        // single-word packet
        send(16'h500, 1'b1, 1'b1, 16'h55);
`ifndef CPRI_BLK_PAD_EN
        @(negedge clk);
        bus.s_vld = 1'b0;
        #1;
        check("t5_wlast", 64'(bus.wr_wlast), 1);
        check("t5_addr", 64'(bus.wr_addr), 0);
`endif
        settle(12);
        check_block("t5", 1, 16'h500, 32'h0055_0001);
        check("t5_blk", 64'(blk_cnt), 5);
        check("t5_trunc", 64'(trunc_cnt), 1);

        // reset mid-packet
        send(16'h600, 1'b1, 1'b0, 16'h66);
        send(16'h601, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        bus.s_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("t6_rdy", 64'(bus.s_rdy), 0);
        check("t6_blk", 64'(blk_cnt), 0);
        check("t6_err", 64'(err_cnt), 0);
        check("t6_nwr", 64'(qa.size()), 2);
        foreach (ql[i]) check("t6_nolast", 64'(ql[i]), 0);
        rst = 1'b0;
        #1;
        check("t6_rdy_up", 64'(bus.s_rdy), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
